// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encoding
// and the default operand width.
package div_pkg;

   localparam int DEF_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } div_state_e;

endpackage : div_pkg

// File: rtl/seq_divider4bit_if.sv
// Start/busy/done handshake and operand/result bundle of the divider.
interface seq_divider4bit_if #(
   parameter int WIDTH = div_pkg::DEF_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface : seq_divider4bit_if

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step #(
   parameter int WIDTH = div_pkg::DEF_WIDTH
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic             q_bit_o
);

   logic [WIDTH+1:0] t_s;

   // Compare on WIDTH+2 bits so no bit of the incoming remainder is lost;
   // when the divisor fits, t < 2*divisor so the difference fits WIDTH+1 bits.
   always_comb begin
      t_s     = {rem_i, bit_i};
      rem_o   = t_s[WIDTH:0];
      q_bit_o = 1'b0;
      if (t_s >= {2'b00, divisor_i}) begin
         rem_o   = t_s[WIDTH:0] - {1'b0, divisor_i};
         q_bit_o = 1'b1;
      end else begin
         rem_o   = t_s[WIDTH:0];
         q_bit_o = 1'b0;
      end
   end

endmodule : div_step

// File: rtl/seq_divider4bit.sv
// Sequential unsigned restoring divider, one quotient bit per clock,
// with divide-by-zero flagged instead of computed.
module seq_divider4bit
   import div_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_divider4bit_if.slave   bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   div_state_e       state_q, state_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             dbz_q, dbz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   step_rem_s;
   logic             step_q_bit_s;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .bit_i     (dvd_q[WIDTH-1]),
      .divisor_i (dvs_q),
      .rem_o     (step_rem_s),
      .q_bit_o   (step_q_bit_s)
   );

   // Next-state, datapath and result logic. Quotient bits shift into the
   // vacated LSBs of the dividend register as its MSBs are consumed.
   always_comb begin
      state_d = state_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      quo_d   = quo_q;
      remo_d  = remo_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.divisor != {WIDTH{1'b0}}) begin
                  dvd_d   = bus.dividend;
                  dvs_d   = bus.divisor;
                  rem_d   = {(WIDTH+1){1'b0}};
                  cnt_d   = CW'(WIDTH - 1);
                  state_d = RUN;
               end else begin
                  quo_d   = {WIDTH{1'b1}};
                  remo_d  = bus.dividend;
                  dbz_d   = 1'b1;
                  state_d = FIN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            dvd_d = {dvd_q[WIDTH-2:0], step_q_bit_s};
            rem_d = step_rem_s;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == {CW{1'b0}}) begin
               quo_d   = {dvd_q[WIDTH-2:0], step_q_bit_s};
               remo_d  = step_rem_s[WIDTH-1:0];
               dbz_d   = 1'b0;
               state_d = FIN;
            end else begin
               state_d = RUN;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == FIN);
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         dvd_q   <= {WIDTH{1'b0}};
         dvs_q   <= {WIDTH{1'b0}};
         rem_q   <= {(WIDTH+1){1'b0}};
         cnt_q   <= {CW{1'b0}};
         quo_q   <= {WIDTH{1'b0}};
         remo_q  <= {WIDTH{1'b0}};
         dbz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         quo_q   <= quo_d;
         remo_q  <= remo_d;
         dbz_q   <= dbz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.quotient    = quo_q;
   assign bus.remainder   = remo_q;
   assign bus.div_by_zero = dbz_q;

endmodule : seq_divider4bit

// File: tb/tb_seq_divider4bit.sv
// Self-checking bench for seq_divider4bit against an arithmetic reference.
module tb_seq_divider4bit;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   seq_divider4bit_if #(.WIDTH(4)) dif ();

   seq_divider4bit #(.WIDTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer division, divide-by-zero gives all ones / dividend.
   task automatic ref_div(input int a, input int b, output int q, output int r, output int z);
      if (b == 0) begin
         q = 15; r = a; z = 1;
      end else begin
         q = a / b; r = a % b; z = 0;
      end
   endtask

   task automatic do_div(input logic [3:0] a, input logic [3:0] b, input bit inject);
      int q, r, z, cyc, bcnt, ov, extra;
      bit seen;
      ref_div(int'(a), int'(b), q, r, z);
      @(negedge clk);
      dif.start = 1'b1; dif.dividend = a; dif.divisor = b;
      @(posedge clk); #1;
      dif.start = 1'b0;
      dif.dividend = 4'($urandom); dif.divisor = 4'($urandom);
      cyc = 0; bcnt = 0; ov = 0; seen = 1'b0;
      while (!seen && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (dif.busy) bcnt++;
         if (dif.busy && dif.done) ov++;
         if (dif.done) seen = 1'b1;
         else if (inject && cyc == 2) begin
            dif.start = 1'b1;
            dif.dividend = 4'($urandom);
            dif.divisor = 4'($urandom_range(15, 1));
         end else dif.start = 1'b0;
      end
      dif.start = 1'b0;
      check_val("done_seen", 32'(seen), 32'd1);
      check_val("latency", cyc, (b == 4'd0) ? 32'd1 : 32'd5);
      check_val("busy_cycles", bcnt, (b == 4'd0) ? 32'd0 : 32'd4);
      check_val("busy_done_overlap", ov, 32'd0);
      check_val("quotient", 32'(dif.quotient), q);
      check_val("remainder", 32'(dif.remainder), r);
      check_val("div_by_zero", 32'(dif.div_by_zero), z);
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (dif.done) extra++;
      end
      check_val("extra_done", extra, 32'd0);
      check_val("hold_quotient", 32'(dif.quotient), q);
      check_val("hold_remainder", 32'(dif.remainder), r);
   endtask

   initial begin
      int q, r, z, cyc, extra, a, b, exp_lat;
      bit seen;
      rst_n = 1'b0;
      dif.start = 1'b0; dif.dividend = 4'd0; dif.divisor = 4'd0;
      repeat (3) @(negedge clk);
      check_val("rst_busy", 32'(dif.busy), 32'd0);
      check_val("rst_done", 32'(dif.done), 32'd0);
      check_val("rst_quotient", 32'(dif.quotient), 32'd0);
      check_val("rst_remainder", 32'(dif.remainder), 32'd0);
      check_val("rst_dbz", 32'(dif.div_by_zero), 32'd0);
      rst_n = 1'b1;

      do_div(4'd13, 4'd3, 1'b0);

      // Reset during the second RUN cycle aborts without a done pulse.
      @(negedge clk);
      dif.start = 1'b1; dif.dividend = 4'd11; dif.divisor = 4'd2;
      @(posedge clk); #1;
      dif.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("abort_busy", 32'(dif.busy), 32'd0);
      check_val("abort_done", 32'(dif.done), 32'd0);
      check_val("abort_quotient", 32'(dif.quotient), 32'd0);
      check_val("abort_remainder", 32'(dif.remainder), 32'd0);
      check_val("abort_dbz", 32'(dif.div_by_zero), 32'd0);
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (dif.done) extra++;
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (dif.done) extra++;
      end
      check_val("abort_no_done", extra, 32'd0);

      do_div(4'd9, 4'd2, 1'b0);
      do_div(4'd2, 4'd9, 1'b0);
      do_div(4'd15, 4'd1, 1'b0);
      do_div(4'd15, 4'd15, 1'b0);
      do_div(4'd14, 4'd4, 1'b1);
      do_div(4'd7, 4'd0, 1'b0);
      do_div(4'd6, 4'd3, 1'b0);

      for (int k = 0; k < 40; k++) begin
         do_div(4'($urandom), 4'($urandom), 1'($urandom));
      end

      // Exhaustive back-to-back sweep with start held high.
      @(negedge clk);
      dif.start = 1'b1; dif.dividend = 4'd0; dif.divisor = 4'd0;
      for (int i = 0; i < 256; i++) begin
         a = i >> 4;
         b = i & 15;
         ref_div(a, b, q, r, z);
         cyc = 0; seen = 1'b0;
         while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (dif.done) seen = 1'b1;
         end
         if (i < 255) begin
            dif.dividend = 4'((i + 1) >> 4);
            dif.divisor  = 4'((i + 1) & 15);
         end
         exp_lat = ((b == 0) ? 1 : 5) + ((i > 0) ? 1 : 0);
         check_val("sweep_latency", cyc, exp_lat);
         check_val("sweep_quotient", 32'(dif.quotient), q);
         check_val("sweep_remainder", 32'(dif.remainder), r);
         check_val("sweep_dbz", 32'(dif.div_by_zero), z);
      end
      @(negedge clk);
      dif.start = 1'b0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_seq_divider4bit
